// File: rtl/fifo_param_thresh.sv
// Parametrised synchronous FIFO with registered read port, programmable
// almost-full/almost-empty thresholds and overflow/underflow reporting.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky (cleared by reset or cfg_load).
module fifo_param_thresh #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)  // derived from DEPTH; leave at default
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] sup_threshold,
  input  logic [ADDR_W-1:0] inf_threshold,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SUP_RST  = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] INF_RST  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] sup_th_q, sup_th_d;
  logic [ADDR_W-1:0] inf_th_q, inf_th_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic push_ok, pop_ok, ovf_evt, unf_evt;

  // Flags depend only on registered occupancy and thresholds.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= {1'b0, sup_th_q});
  assign almost_empty = (count_q <= {1'b0, inf_th_q});

  assign count     = count_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    ovf_evt = push && !push_ok;
    unf_evt = pop && empty;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    data_d  = pop_ok ? mem_q[rd_ptr_q] : data_q;
    valid_d = pop_ok;

    sup_th_d = cfg_load ? sup_threshold : sup_th_q;
    inf_th_d = cfg_load ? inf_threshold : inf_th_q;

`ifdef FIFO_STICKY_ERR_EN
    // A fresh error on the clearing edge still gets reported.
    ovf_d = (cfg_load ? 1'b0 : ovf_q) | ovf_evt;
    unf_d = (cfg_load ? 1'b0 : unf_q) | unf_evt;
`else
    ovf_d = ovf_evt;
    unf_d = unf_evt;
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sup_th_q <= SUP_RST;
      inf_th_q <= INF_RST;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sup_th_q <= sup_th_d;
      inf_th_q <= inf_th_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_fifo_param_thresh.sv
// Directed, table-driven bench for fifo_param_thresh (DATA_W=10, DEPTH=8),
// plus hand-written sequences for mid-stream reset and full-rate push+pop at full.
module tb_fifo_param_thresh;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L;
  logic       cfg_load;
  logic [2:0] sup_threshold, inf_threshold;
  logic       push, pop;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  fifo_param_thresh #(.DATA_W(10), .DEPTH(8)) dut (
    .clk(clk), .reset_L(reset_L), .cfg_load(cfg_load),
    .sup_threshold(sup_threshold), .inf_threshold(inf_threshold),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push, pop, cfg;
    logic [9:0] din;
    logic [2:0] sup, inf;
    logic [3:0] cnt;
    logic       full, empty, af, ae, valid;
    logic [9:0] dout;
    logic       ovf, unf;   // error event caused by this row's edge
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pu, input logic po, input logic cf,
                              input int din, input int sup, input int inf,
                              input int cnt, input logic fu, input logic em,
                              input logic af, input logic ae, input logic va,
                              input int dout, input logic ov, input logic un);
    vec_t v;
    v.push = pu; v.pop = po; v.cfg = cf;
    v.din = 10'(din); v.sup = 3'(sup); v.inf = 3'(inf);
    v.cnt = 4'(cnt); v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.valid = va;
    v.dout = 10'(dout); v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic cf,
                      input logic [9:0] din, input logic [2:0] sup, input logic [2:0] inf);
    @(negedge clk);
    push = pu; pop = po; cfg_load = cf;
    data_in = din; sup_threshold = sup; inf_threshold = inf;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic fu, input logic em,
                           input logic af, input logic ae);
    chk({tag, "_count"}, int'(count), cnt);
    chk({tag, "_full"},  int'(full), int'(fu));
    chk({tag, "_empty"}, int'(empty), int'(em));
    chk({tag, "_afull"}, int'(almost_full), int'(af));
    chk({tag, "_aempty"}, int'(almost_empty), int'(ae));
  endtask

  initial begin
    logic ovf_m, unf_m;
    int c, d;

    reset_L = 1'b0; cfg_load = 1'b0; push = 1'b0; pop = 1'b0;
    data_in = '0; sup_threshold = '0; inf_threshold = '0;
    ovf_m = 1'b0; unf_m = 1'b0;

    // push 1..8 with default thresholds sup=6, inf=1
    for (int k = 1; k <= 8; k++)
      add(1,0,0, k,0,0, k, k==8, 0, k>=6, k<=1, 0, 0, 0,0);
    add(1,0,0, 9,0,0, 8, 1,0,1,0, 0, 0, 1,0);          // push on full: dropped
    add(0,0,0, 0,0,0, 8, 1,0,1,0, 0, 0, 0,0);
    for (int j = 1; j <= 8; j++) begin
      c = 8 - j;
      add(0,1,0, 0,0,0, c, 0, c==0, c>=6, c<=1, 1, j, 0,0);
    end
    add(0,1,0, 0,0,0, 0, 0,1,0,1, 0, 8, 0,1);          // pop on empty
    add(0,0,0, 0,0,0, 0, 0,1,0,1, 0, 8, 0,0);
    for (int k = 1; k <= 3; k++)
      add(1,0,0, 20+k,0,0, k, 0,0,0, k<=1, 0, 8, 0,0);
    for (int i = 0; i < 5; i++) begin
      d = (i < 3) ? 21 + i : 11 + (i - 3);
      add(1,1,0, 11+i,0,0, 3, 0,0,0,0, 1, d, 0,0);
    end
    add(0,0,1, 0,2,0, 3, 0,0,1,0, 0, 12, 0,0);         // sup=2, inf=0
    for (int j = 0; j < 3; j++) begin
      c = 2 - j;
      add(0,1,0, 0,0,0, c, 0, c==0, c>=2, c==0, 1, 13+j, 0,0);
    end
    add(1,1,0, 40,0,0, 1, 0,0,0,0, 0, 15, 0,1);        // empty push+pop: push only
    add(0,1,0, 0,0,0, 0, 0,1,0,1, 1, 40, 0,0);

    repeat (2) @(posedge clk);
    #1;
    chk_flags("rst", 0, 0, 1, 0, 1);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
    @(negedge clk);
    reset_L = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      step(v.push, v.pop, v.cfg, v.din, v.sup, v.inf);
      if (STICKY) begin
        ovf_m = (v.cfg ? 1'b0 : ovf_m) | v.ovf;
        unf_m = (v.cfg ? 1'b0 : unf_m) | v.unf;
      end else begin
        ovf_m = v.ovf;
        unf_m = v.unf;
      end
      chk_flags($sformatf("v%0d", i), int'(v.cnt), v.full, v.empty, v.af, v.ae);
      chk($sformatf("v%0d_valid", i), int'(valid_out), int'(v.valid));
      chk($sformatf("v%0d_dout", i), int'(data_out), int'(v.dout));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(ovf_m));
      chk($sformatf("v%0d_unf", i), int'(underflow), int'(unf_m));
    end

    // Mid-stream asynchronous reset at count=5 with valid_out high.
    for (int k = 0; k < 6; k++) step(1, 0, 0, 10'(100 + k), 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_valid", int'(valid_out), 1);
    chk("pre_rst_dout", int'(data_out), 100);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk_flags("mid_rst", 0, 0, 1, 0, 1);
    chk("mid_rst_valid", int'(valid_out), 0);
    chk("mid_rst_dout", int'(data_out), 0);
    chk("mid_rst_unf", int'(underflow), 0);
    @(negedge clk);
    reset_L = 1'b1;

    step(1, 0, 0, 10'h55, 0, 0);
    step(1, 0, 0, 10'h66, 0, 0);
    chk("post_rst_count", int'(count), 2);
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst_pop0", int'(data_out), 'h55);
    step(0, 1, 0, 0, 0, 0);
    chk("post_rst_pop1", int'(data_out), 'h66);
    chk_flags("post_rst", 0, 0, 1, 0, 1);

    // Fill, then push+pop at full: one word each way, no overflow.
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 10'(200 + k), 0, 0);
      if (k == 4) chk("fill5_afull", int'(almost_full), 0);
      if (k == 5) chk("fill6_afull", int'(almost_full), 1);
    end
    chk_flags("filled", 8, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 10'(300 + i), 0, 0);
      chk($sformatf("fullrate%0d_count", i), int'(count), 8);
      chk($sformatf("fullrate%0d_dout", i), int'(data_out), 200 + i);
      chk($sformatf("fullrate%0d_valid", i), int'(valid_out), 1);
      chk($sformatf("fullrate%0d_ovf", i), int'(overflow), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("drain%0d_dout", i), int'(data_out), (i < 5) ? 203 + i : 300 + (i - 5));
    end
    chk_flags("drained", 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_param_thresh.md
# fifo_param_thresh

Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds and overflow/underflow detection. It is the generalised successor of the fixed 10-bit, 8-entry FIFO, with configurable data width and depth. It adds:

- a registered read port with a valid strobe;
- an almost-empty flag;
- error reporting.

It sits between a producer (push side) and a consumer (pop side) in the same clock domain, and is the buffering primitive for the per-channel datapaths.

## Interface
Parameters:
- DATA_W, 10, data word width.
- DEPTH, 8, number of entries; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- cfg_load  input  1  when 1, captures the threshold inputs into the threshold registers this cycle.
- sup_threshold  input  ADDR_W  almost-full threshold.
- inf_threshold  input  ADDR_W  almost-empty threshold.
- push  input  1  write request.
- data_in  input  DATA_W  write data.
- pop  input  1  read request.
- data_out  output  DATA_W  registered read data.
- valid_out  output  1  data_out holds a newly popped word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= sup_th_reg.
- almost_empty  output  1  count <= inf_th_reg.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  a push was dropped.
- underflow  output  1  a pop was ignored.

## Operation
Storage and pointers:
- Storage is DEPTH×DATA_W.
- wr_ptr and rd_ptr are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0.
- count is ADDR_W+1 bits wide and tracks occupancy.

Push and pop acceptance:
- A push is accepted when push=1 and (!full, or pop is also accepted this cycle). On acceptance: write mem[wr_ptr] and increment wr_ptr.
- A pop is accepted when pop=1 and !empty. On acceptance: data_out <= mem[rd_ptr], valid_out <= 1, increment rd_ptr.
- If no pop is accepted, valid_out <= 0 and data_out holds its previous value.

count update:
- Push accepted only: count + 1.
- Pop accepted only: count - 1.
- Both accepted: count unchanged.
- Neither: count unchanged.

Boundary cases:
- Full with push and pop: both are accepted, count stays DEPTH, no overflow.
- Full with push only: the write is dropped, pointers are unchanged, overflow is asserted.
- Empty with pop (with or without push): the pop is ignored and underflow is asserted. A simultaneous push is still accepted (count becomes 1). There is no bypass; the pushed word is read on a later pop.

Flags:
- full, empty, almost_full and almost_empty are combinational from count and the threshold registers only. There is no path from push/pop to any flag.
- Threshold comparisons zero-extend the thresholds to ADDR_W+1 bits.

Threshold registers (sup_th_reg, inf_th_reg):
- Reset values are DEPTH-2 and 1.
- They load when cfg_load=1. FIFO contents and pointers are unaffected by the load.
- The new thresholds affect the flags from the next cycle.
- No consistency check is made; sup < inf is legal and each flag simply follows its own comparison.

Reset (reset_L low, asynchronous):
- Outputs: data_out=0, valid_out=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Internal: pointers=0, thresholds at their reset values.
- Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately.

## Timing
- Push-to-visible: a word pushed at edge N is poppable at edge N+1. empty deasserts after edge N.
- Pop latency: for a pop accepted at edge N, data_out and valid_out are valid after edge N, for one cycle only unless popped again.
- Back-to-back pops yield one word per cycle, in FIFO order.
- overflow and underflow are registered: they go high after the offending edge.
- Full throughput with push and pop at count=DEPTH: one word per cycle in and out.

## Configuration
- FIFO_STICKY_ERR_EN defined: overflow and underflow are sticky and stay 1 until reset_L is asserted or cfg_load=1, which clears both on that edge.
- Not defined: overflow and underflow are single-cycle pulses, high only in the cycle after each offending edge.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then push 1..8 with DEPTH=8, sup=6 → almost_full rises when count reaches 6; full=1 at count 8; count=8; no overflow.
- Push 9 while full, pop=0 → write dropped, count stays 8, overflow=1 (sticky build: stays 1; pulse build: one cycle).
- Pop 9 times from full → data_out 1..8 in order with valid_out each cycle; almost_empty rises at count 1; 9th pop gives underflow=1 and valid_out=0.
- Fill to 3 words, then push+pop together for 5 cycles with data_in 11..15 → count stays 3; data_out returns the oldest words in order; no error flags.
- cfg_load with sup=2, inf=0 at count=3 → next cycle almost_full=1, almost_empty=0; sticky errors clear.
- Assert reset_L mid-stream at count=5 → immediately count=0, empty=1, valid_out=0; the next push/pop sequence starts cleanly from pointer 0.
